// File: rtl/sbox_init_engine.sv
// sbox_init_engine: fills the RC4 S-array, one address per cycle, in identity,
// constant or descending order, honouring write back-pressure. Owns the
// S-array write port until done, then releases it to the key scheduler.
// Optional feature macro: SBOX_INIT_VERIFY_EN adds a read-back verify pass
// (VERIFY state, rdata_in / verify_error ports, compare pipeline register).
// rdata_in must present the word addressed by address_out in the cycle that
// follows the edge on which that address was driven.
module sbox_init_engine #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8,
    parameter int DEPTH  = 256
) (
    input  logic              clk,
    input  logic              master_reset,
    input  logic              start,
    input  logic [1:0]        mode,
    input  logic [DATA_W-1:0] fill_value,
    input  logic              stall,
`ifdef SBOX_INIT_VERIFY_EN
    input  logic [DATA_W-1:0] rdata_in,
    output logic              verify_error,
`endif
    output logic [ADDR_W-1:0] address_out,
    output logic [DATA_W-1:0] data_out,
    output logic              write_out,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
`ifdef SBOX_INIT_VERIFY_EN
        VERIFY,
`endif
        DONE
    } state_t;

    // The index is one bit wider than the address so DEPTH == 2**ADDR_W
    // can be counted without wrapping.
    localparam logic [ADDR_W:0] IDX_LAST = (ADDR_W+1)'(DEPTH - 1);
`ifdef SBOX_INIT_VERIFY_EN
    localparam logic [ADDR_W:0] IDX_END  = (ADDR_W+1)'(DEPTH);
`endif

    state_t            state_q, state_d;
    logic [ADDR_W:0]   idx_q, idx_d;
    logic [ADDR_W:0]   nextIdx;
    logic [1:0]        mode_q, mode_d;
    logic [DATA_W-1:0] fill_q, fill_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              write_q, write_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              startAccepted;
    logic              lastWrite;

`ifdef SBOX_INIT_VERIFY_EN
    logic              cmpValid_q, cmpValid_d;
    logic [DATA_W-1:0] cmpExp_q, cmpExp_d;
    logic              mismatch_q, mismatch_d;
    logic              verifyErr_q, verifyErr_d;
`endif

    // Value written at index i for a given fill mode; mode 11 behaves as identity.
    function automatic logic [DATA_W-1:0] fillData(input logic [1:0]        m,
                                                   input logic [DATA_W-1:0] f,
                                                   input logic [ADDR_W:0]   i);
        logic [ADDR_W:0] desc;
        desc = IDX_LAST - i;
        case (m)
            2'b01:   fillData = f;
            2'b10:   fillData = DATA_W'(desc);
            default: fillData = DATA_W'(i);
        endcase
    endfunction

    assign nextIdx       = idx_q + (ADDR_W+1)'(1);
    assign startAccepted = start && ((state_q == IDLE) || (state_q == DONE));
    assign lastWrite     = (state_q == WRITE) && write_q && !stall && (idx_q == IDX_LAST);

    // State register; reset abandons any partial fill.
    always_ff @(posedge clk or posedge master_reset) begin
        if (master_reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state selection: start only counts when not busy.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = WRITE;
                end
            end
            WRITE: begin
                if (lastWrite) begin
`ifdef SBOX_INIT_VERIFY_EN
                    state_d = VERIFY;
`else
                    state_d = DONE;
`endif
                end
            end
`ifdef SBOX_INIT_VERIFY_EN
            VERIFY: begin
                if (idx_q == IDX_END) begin
                    state_d = DONE;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    // Next values of the registered outputs and the fill index; the first
    // WRITE cycle only loads the bus, later cycles advance on each accepted write.
    always_comb begin
        idx_d   = idx_q;
        mode_d  = mode_q;
        fill_d  = fill_q;
        addr_d  = addr_q;
        data_d  = data_q;
        write_d = write_q;
        busy_d  = busy_q;
        done_d  = done_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    mode_d  = mode;
                    fill_d  = fill_value;
                    idx_d   = '0;
                    addr_d  = '0;
                    data_d  = '0;
                    write_d = 1'b0;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                end
            end
            WRITE: begin
                if (!write_q) begin
                    addr_d  = idx_q[ADDR_W-1:0];
                    data_d  = fillData(mode_q, fill_q, idx_q);
                    write_d = 1'b1;
                end else if (!stall) begin
                    if (idx_q == IDX_LAST) begin
                        idx_d   = '0;
                        addr_d  = '0;
                        data_d  = '0;
                        write_d = 1'b0;
`ifndef SBOX_INIT_VERIFY_EN
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
`endif
                    end else begin
                        idx_d  = nextIdx;
                        addr_d = nextIdx[ADDR_W-1:0];
                        data_d = fillData(mode_q, fill_q, nextIdx);
                    end
                end
            end
`ifdef SBOX_INIT_VERIFY_EN
            VERIFY: begin
                if (idx_q == IDX_END) begin
                    idx_d  = '0;
                    addr_d = '0;
                    busy_d = 1'b0;
                    done_d = 1'b1;
                end else if (idx_q == IDX_LAST) begin
                    idx_d  = IDX_END;
                    addr_d = '0;
                end else begin
                    idx_d  = nextIdx;
                    addr_d = nextIdx[ADDR_W-1:0];
                end
            end
`endif
            default: begin
                idx_d   = '0;
                addr_d  = '0;
                data_d  = '0;
                write_d = 1'b0;
                busy_d  = 1'b0;
                done_d  = 1'b0;
            end
        endcase
    end

    // Datapath and output registers; all outputs drop to zero on reset.
    always_ff @(posedge clk or posedge master_reset) begin
        if (master_reset) begin
            idx_q   <= '0;
            mode_q  <= '0;
            fill_q  <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            write_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            idx_q   <= idx_d;
            mode_q  <= mode_d;
            fill_q  <= fill_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            write_q <= write_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

`ifdef SBOX_INIT_VERIFY_EN
    // Verify pipeline: the expected word travels alongside each read address,
    // is compared against rdata_in one cycle later, and the error stays sticky
    // until the next accepted start.
    always_comb begin
        cmpValid_d  = 1'b0;
        cmpExp_d    = cmpExp_q;
        if (lastWrite) begin
            cmpValid_d = 1'b1;
            cmpExp_d   = fillData(mode_q, fill_q, '0);
        end else if ((state_q == VERIFY) && (idx_q < IDX_LAST)) begin
            cmpValid_d = 1'b1;
            cmpExp_d   = fillData(mode_q, fill_q, nextIdx);
        end
        mismatch_d  = cmpValid_q && (rdata_in != cmpExp_q);
        verifyErr_d = startAccepted ? 1'b0 : (verifyErr_q | mismatch_q);
    end

    // Verify pipeline registers.
    always_ff @(posedge clk or posedge master_reset) begin
        if (master_reset) begin
            cmpValid_q  <= 1'b0;
            cmpExp_q    <= '0;
            mismatch_q  <= 1'b0;
            verifyErr_q <= 1'b0;
        end else begin
            cmpValid_q  <= cmpValid_d;
            cmpExp_q    <= cmpExp_d;
            mismatch_q  <= mismatch_d;
            verifyErr_q <= verifyErr_d;
        end
    end

    assign verify_error = verifyErr_q;
`endif

    assign address_out = addr_q;
    assign data_out    = data_q;
    assign write_out   = write_q;
    assign busy        = busy_q;
    assign done        = done_q;

endmodule

// File: tb/tb_sbox_init_engine.sv
// Scoreboard bench for sbox_init_engine: a 256-entry instance (A) and a
// 16-entry instance (B). Stimulus pushes the expected write stream into a
// queue; a negedge monitor pops and compares every accepted write.
`timescale 1ns/1ps
module tb_sbox_init_engine;

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] d;
    } wr_t;

    logic       clk = 1'b0;
    logic       masterReset = 1'b1;

    logic       startA = 1'b0;
    logic [1:0] modeA = 2'b00;
    logic [7:0] fillA = 8'h00;
    logic       stallA = 1'b0;
    logic [7:0] addrA;
    logic [7:0] dataA;
    logic       writeA;
    logic       busyA;
    logic       doneA;
    logic       corruptA = 1'b0;

    logic       startB = 1'b0;
    logic [1:0] modeB = 2'b00;
    logic [7:0] fillB = 8'h00;
    logic       stallB = 1'b0;
    logic [7:0] addrB;
    logic [7:0] dataB;
    logic       writeB;
    logic       busyB;
    logic       doneB;

    logic [7:0] memA [256];
    logic [7:0] memB [256];
    bit         touchedB [256];

    wr_t        expA[$];
    wr_t        expB[$];
    wr_t        eA;
    wr_t        eB;

    int         checks = 0;
    int         errors = 0;

`ifdef SBOX_INIT_VERIFY_EN
    logic [7:0] rdataA;
    logic [7:0] rdataB;
    logic       verrA;
    logic       verrB;
    assign rdataA = memA[addrA];
    assign rdataB = memB[addrB];
`endif

    sbox_init_engine #(.ADDR_W(8), .DATA_W(8), .DEPTH(256)) dutA (
        .clk          (clk),
        .master_reset (masterReset),
        .start        (startA),
        .mode         (modeA),
        .fill_value   (fillA),
        .stall        (stallA),
`ifdef SBOX_INIT_VERIFY_EN
        .rdata_in     (rdataA),
        .verify_error (verrA),
`endif
        .address_out  (addrA),
        .data_out     (dataA),
        .write_out    (writeA),
        .busy         (busyA),
        .done         (doneA)
    );

    sbox_init_engine #(.ADDR_W(8), .DATA_W(8), .DEPTH(16)) dutB (
        .clk          (clk),
        .master_reset (masterReset),
        .start        (startB),
        .mode         (modeB),
        .fill_value   (fillB),
        .stall        (stallB),
`ifdef SBOX_INIT_VERIFY_EN
        .rdata_in     (rdataB),
        .verify_error (verrB),
`endif
        .address_out  (addrB),
        .data_out     (dataB),
        .write_out    (writeB),
        .busy         (busyB),
        .done         (doneB)
    );

    always #5 clk = ~clk;

    // One comparison: bumps the check count, reports and counts a failure.
    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Word expected at index i for a fill of the given depth and mode.
    function automatic logic [7:0] expData(input int depth, input logic [1:0] m,
                                           input logic [7:0] f, input int i);
        int desc;
        desc = depth - 1 - i;
        case (m)
            2'b01:   return f;
            2'b10:   return desc[7:0];
            default: return i[7:0];
        endcase
    endfunction

    // Memory models: a write lands on the edge where write_out is high and
    // stall is low; instance A can corrupt address 0x33.
    always @(posedge clk) begin
        if (writeA && !stallA) begin
            memA[addrA] <= (corruptA && addrA == 8'h33) ? ~dataA : dataA;
        end
        if (writeB && !stallB) begin
            memB[addrB]     <= dataB;
            touchedB[addrB] <= 1'b1;
        end
    end

    // Monitor: every accepted write must match the head of its queue in order,
    // which also rules out skipped or duplicated addresses.
    always @(negedge clk) begin
        if (!masterReset) begin
            checkOutput("busyDoneExclusiveA", {31'd0, busyA & doneA}, 32'd0);
            checkOutput("writeImpliesBusyA", {31'd0, writeA & ~busyA}, 32'd0);
            if (writeA && !stallA) begin
                if (expA.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL extraWriteA actual=addr %0h required=no write", addrA);
                end else begin
                    eA = expA.pop_front();
                    checkOutput("writeAddrA", {24'd0, addrA}, {24'd0, eA.a});
                    checkOutput("writeDataA", {24'd0, dataA}, {24'd0, eA.d});
                end
            end
            if (writeB && !stallB) begin
                if (expB.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL extraWriteB actual=addr %0h required=no write", addrB);
                end else begin
                    eB = expB.pop_front();
                    checkOutput("writeAddrB", {24'd0, addrB}, {24'd0, eB.a});
                    checkOutput("writeDataB", {24'd0, dataB}, {24'd0, eB.d});
                end
            end
        end
    end

    // Full run on instance A: optional 3-cycle stall at address 0x10, optional
    // reset at address 0x40, optional corruption of address 0x33.
    task automatic applyStimulus(input logic [1:0] m, input logic [7:0] f, input bit doStall,
                                 input bit doReset, input bit corrupt);
        wr_t w;
        int  lat;
        int  stallsLeft;
        int  expLat;
        bit  finished;
        corruptA = corrupt;
        for (int i = 0; i < 256; i++) begin
            w.a = 8'(i);
            w.d = expData(256, m, f, i);
            expA.push_back(w);
        end
        @(posedge clk); #1;
        modeA  = m;
        fillA  = f;
        startA = 1'b1;
        @(posedge clk); #1;
        startA = 1'b0;
        fillA  = 8'h00;
        modeA  = 2'b00;
        checkOutput("busyAfterStart", {31'd0, busyA}, 32'd1);
        checkOutput("doneAfterStart", {31'd0, doneA}, 32'd0);
`ifdef SBOX_INIT_VERIFY_EN
        checkOutput("verifyErrCleared", {31'd0, verrA}, 32'd0);
`endif
        lat        = 0;
        stallsLeft = doStall ? 3 : 0;
        finished   = 1'b0;
        while (!finished && lat < 2 * 256 + 20) begin
            @(posedge clk); #1;
            lat++;
            if (doReset && writeA && addrA == 8'h40) begin
                masterReset = 1'b1;
                #1;
                checkOutput("resetAddr", {24'd0, addrA}, 32'd0);
                checkOutput("resetData", {24'd0, dataA}, 32'd0);
                checkOutput("resetWrite", {31'd0, writeA}, 32'd0);
                checkOutput("resetBusy", {31'd0, busyA}, 32'd0);
                checkOutput("resetDone", {31'd0, doneA}, 32'd0);
                expA.delete();
                @(posedge clk); #1;
                masterReset = 1'b0;
                return;
            end
            if (stallA) begin
                checkOutput("stallHoldAddr", {24'd0, addrA}, 32'h10);
                checkOutput("stallHoldData", {24'd0, dataA}, 32'h10);
                checkOutput("stallHoldWrite", {31'd0, writeA}, 32'd1);
            end
            stallA = (stallsLeft > 0) && writeA && (addrA == 8'h10);
            if (stallA) begin
                stallsLeft--;
            end
`ifdef SBOX_INIT_VERIFY_EN
            if (!doStall && lat >= 257 && lat <= 512) begin
                checkOutput("readSweepAddr", {24'd0, addrA}, 32'(lat - 257));
                checkOutput("readSweepNoWrite", {31'd0, writeA}, 32'd0);
            end
`endif
            if (doneA) begin
                finished = 1'b1;
            end
        end
        stallA = 1'b0;
`ifdef SBOX_INIT_VERIFY_EN
        expLat = 514;
`else
        expLat = 257;
`endif
        if (doStall) begin
            expLat = expLat + 3;
        end
        checkOutput("doneLatency", finished ? 32'(lat) : 32'd0, 32'(expLat));
        checkOutput("doneBusyLow", {31'd0, busyA}, 32'd0);
        checkOutput("doneAddrZero", {24'd0, addrA}, 32'd0);
        checkOutput("doneDataZero", {24'd0, dataA}, 32'd0);
        checkOutput("doneWriteZero", {31'd0, writeA}, 32'd0);
        checkOutput("noSkippedWrites", 32'(expA.size()), 32'd0);
`ifdef SBOX_INIT_VERIFY_EN
        checkOutput("verifyError", {31'd0, verrA}, {31'd0, corrupt});
`endif
        @(posedge clk); #1;
        checkOutput("doneIsLevel", {31'd0, doneA}, 32'd1);
        corruptA = 1'b0;
    endtask

    // Descending fill on the 16-entry instance; addresses 16..255 stay untouched.
    task automatic applyStimulusSmall();
        wr_t w;
        int  lat;
        int  bad;
        int  expLat;
        bit  finished;
        for (int i = 0; i < 16; i++) begin
            w.a = 8'(i);
            w.d = expData(16, 2'b10, 8'h00, i);
            expB.push_back(w);
        end
        @(posedge clk); #1;
        modeB  = 2'b10;
        startB = 1'b1;
        @(posedge clk); #1;
        startB   = 1'b0;
        lat      = 0;
        finished = 1'b0;
        while (!finished && lat < 60) begin
            @(posedge clk); #1;
            lat++;
            if (doneB) begin
                finished = 1'b1;
            end
        end
`ifdef SBOX_INIT_VERIFY_EN
        expLat = 34;
        checkOutput("verifyErrorB", {31'd0, verrB}, 32'd0);
`else
        expLat = 17;
`endif
        checkOutput("doneLatencyB", finished ? 32'(lat) : 32'd0, 32'(expLat));
        checkOutput("noSkippedWritesB", 32'(expB.size()), 32'd0);
        checkOutput("memB0", {24'd0, memB[0]}, 32'd15);
        checkOutput("memB15", {24'd0, memB[15]}, 32'd0);
        checkOutput("memB7", {24'd0, memB[7]}, 32'd8);
        bad = 0;
        for (int i = 16; i < 256; i++) begin
            if (touchedB[i]) begin
                bad++;
            end
        end
        checkOutput("untouchedAbove15", 32'(bad), 32'd0);
    endtask

    // Main sequence: reset, identity, constant, small descending, stall,
    // reset mid-run, recovery fill and (with the macro) verify passes.
    initial begin
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rstAddrA", {24'd0, addrA}, 32'd0);
        checkOutput("rstDataA", {24'd0, dataA}, 32'd0);
        checkOutput("rstWriteA", {31'd0, writeA}, 32'd0);
        checkOutput("rstBusyA", {31'd0, busyA}, 32'd0);
        checkOutput("rstDoneA", {31'd0, doneA}, 32'd0);
        checkOutput("rstDoneB", {31'd0, doneB}, 32'd0);
`ifdef SBOX_INIT_VERIFY_EN
        checkOutput("rstVerifyErrA", {31'd0, verrA}, 32'd0);
`endif
        masterReset = 1'b0;
        @(posedge clk); #1;
        checkOutput("idleNoStartBusy", {31'd0, busyA}, 32'd0);

        $display("[TB] identity fill");
        applyStimulus(2'b00, 8'h00, 1'b0, 1'b0, 1'b0);
        $display("[TB] constant fill 0xA5");
        applyStimulus(2'b01, 8'hA5, 1'b0, 1'b0, 1'b0);
        $display("[TB] descending fill depth 16");
        applyStimulusSmall();
        $display("[TB] back-pressure at 0x10");
        applyStimulus(2'b00, 8'h00, 1'b1, 1'b0, 1'b0);
        $display("[TB] reset at 0x40");
        applyStimulus(2'b00, 8'h00, 1'b0, 1'b1, 1'b0);
        $display("[TB] fill after reset");
        applyStimulus(2'b00, 8'h00, 1'b0, 1'b0, 1'b0);
        $display("[TB] mode 11 as identity");
        applyStimulus(2'b11, 8'h5A, 1'b0, 1'b0, 1'b0);
`ifdef SBOX_INIT_VERIFY_EN
        $display("[TB] verify with corruption at 0x33");
        applyStimulus(2'b00, 8'h00, 1'b0, 1'b0, 1'b1);
        $display("[TB] verify clean rerun");
        applyStimulus(2'b00, 8'h00, 1'b0, 1'b0, 1'b0);
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sbox_init_engine.md
# sbox_init_engine

Parametrised memory-initialisation engine for the RC4 datapath. On a `start` pulse it writes a whole on-chip array, at one address per cycle, in one of several fill modes. It supports write back-pressure and an optional read-back verify pass. It sits ahead of the key-scheduling FSM: it owns the S-array write port until `done`, then releases it.

## Interface
- `ADDR_W`, 8, address width of the target memory
- `DATA_W`, 8, data width of the target memory
- `DEPTH`, 256, number of entries written (addresses 0..DEPTH-1); must satisfy 2 <= DEPTH <= 2**ADDR_W

- `clk`  in  1  single clock; all logic on rising edge
- `master_reset`  in  1  reset, asynchronous and active-high; forces state IDLE
- `start`  in  1  one-cycle request; sampled in IDLE and DONE only
- `mode`  in  2  fill mode, latched at start: 00 identity, 01 constant, 10 descending, 11 treated as identity
- `fill_value`  in  DATA_W  constant for mode 01, latched at start
- `stall`  in  1  memory not ready; write not accepted this cycle
- `rdata_in`  in  DATA_W  memory read data, one-cycle read latency (present only with SBOX_INIT_VERIFY_EN)
- `address_out`  out  ADDR_W  memory address
- `data_out`  out  DATA_W  memory write data
- `write_out`  out  1  write enable
- `busy`  out  1  high in every state except IDLE and DONE
- `done`  out  1  level; high in DONE until the next start or reset
- `verify_error`  out  1  sticky mismatch flag (present only with SBOX_INIT_VERIFY_EN)

## Operation
- **States:** IDLE, WRITE, VERIFY (macro only), DONE.
- **Reset values:** all outputs are registered and reset to 0: `address_out`, `data_out`, `write_out`, `busy`, `done`, `verify_error`.
- **IDLE:**
  - `start`=1 latches `mode` and `fill_value`, sets index i=0 and goes to WRITE.
  - `start`=0 stays in IDLE.
- **WRITE:**
  - Drives `address_out`=i, `write_out`=1 and `data_out` according to mode:
    - identity: i, truncated or zero-extended to DATA_W
    - constant: latched `fill_value`
    - descending: (DEPTH-1-i), truncated to DATA_W
  - A write is accepted on a cycle with `write_out`=1 and `stall`=0; i then increments.
  - With `stall`=1, `address_out`, `data_out` and `write_out` hold unchanged.
  - After the write at i=DEPTH-1 is accepted, the engine goes to VERIFY (macro) or DONE.
  - i never wraps: the index counter is ADDR_W+1 bits wide, so DEPTH=2**ADDR_W terminates correctly.
- **VERIFY:**
  - Drives `write_out`=0 and `address_out`=0..DEPTH-1, one per cycle; `stall` is ignored.
  - Each `rdata_in` is compared one cycle later against the expected value for that address.
  - Any mismatch sets `verify_error`.
- **DONE:**
  - `done`=1; `address_out`, `data_out` and `write_out` are all 0.
  - `start`=1 re-enters WRITE directly, as from IDLE.
  - `verify_error` clears on any accepted start.
- **Start elsewhere:** `start` while `busy` is ignored.
- **Reset mid-operation:** outputs go to 0 asynchronously and the state returns to IDLE; the partial fill is abandoned.

## Timing
- `start` sampled at edge k: the first write is driven from edge k+1.
- Without stalls and without the macro:
  - writes occupy cycles k+1..k+DEPTH
  - `done`=1 and `busy`=0 from edge k+DEPTH+1
  - throughput is 1 entry per cycle
- Each stalled cycle adds exactly one cycle of latency.
- With the macro:
  - reads occupy cycles k+DEPTH+1..k+2*DEPTH
  - the final compare happens at k+2*DEPTH+1
  - `done` and the final `verify_error` are valid together from edge k+2*DEPTH+2
- `busy` and `done` are never high together.
- `write_out` is never high outside WRITE.

## Configuration
- **`SBOX_INIT_VERIFY_EN` defined:** adds the VERIFY state, the `rdata_in` and `verify_error` ports, and the compare pipeline register.
- **`SBOX_INIT_VERIFY_EN` undefined:** WRITE goes straight to DONE; neither port exists and there is no read traffic.

## Test plan
- **Identity fill:** defaults, mode 00, start pulse at cycle 0, no stall.
  - 256 writes with mem[i]=i.
  - `done` rises at cycle 257.
  - `write_out` is never asserted twice for the same address.
- **Constant fill:** mode 01, `fill_value`=0xA5; change `fill_value` to 0x00 mid-run.
  - All 256 entries equal 0xA5, because the value is latched at start.
- **Descending fill:** DEPTH=16, mode 10.
  - mem[0]=15 .. mem[15]=0.
  - `done` at cycle 17.
  - Addresses 16..255 are untouched.
- **Back-pressure:** `stall`=1 for 3 cycles while `address_out`=0x10.
  - `address_out` and `data_out` hold at 0x10 for the 3 cycles.
  - `done` at cycle 260; no address is skipped or duplicated.
- **Reset mid-run:** assert `master_reset` at `address_out`=0x40.
  - All outputs read 0 before the next clock edge; state is IDLE.
  - A new start completes a full fill normally.
- **Verify pass (macro defined):** memory model corrupts address 0x33 on write.
  - Read addresses sweep 0..255.
  - `verify_error`=1 and `done`=1 at cycle 514.
  - A clean rerun gives `verify_error`=0.
